// File: rtl/filter_gmii_ifg.sv
// GMII receive inter-frame-gap filter: frames that follow too short an idle gap are
// suppressed whole; compliant frames pass with one cycle of latency.
module filter_gmii_ifg #(
   parameter int C_GAP_WIDTH = 16,
   parameter int C_CNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             gmii_rxd_in,
   input  logic                   gmii_rx_dv_in,
   input  logic                   gmii_rx_er_in,
   input  logic [C_GAP_WIDTH-1:0] min_interframe_gap,
   input  logic                   stats_clear,
   output logic [7:0]             gmii_rxd_out,
   output logic                   gmii_rx_dv_out,
   output logic                   gmii_rx_er_out,
   output logic [C_CNT_WIDTH-1:0] frames_passed,
   output logic [C_CNT_WIDTH-1:0] frames_dropped
);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, PASS, DROP} state_t;

   localparam logic [C_GAP_WIDTH-1:0] GAP_ONE = 1;
   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t                 state, state_nxt;
   logic [C_GAP_WIDTH-1:0] gap_cnt;
   logic                   fwd, inc_pass, inc_drop;
   logic [7:0]             rxd_p1;
   logic                   vld_p1, er_p1;

   function automatic logic [C_GAP_WIDTH-1:0] gap_sat_inc(input logic [C_GAP_WIDTH-1:0] g);
      return (&g) ? g : g + GAP_ONE;
   endfunction

   // Frame-start decision is made on the first dv=1 byte seen in IDLE, so that byte
   // is either forwarded or suppressed along with the rest of the frame.
   always_comb begin
      state_nxt = state;
      fwd       = 1'b0;
      inc_pass  = 1'b0;
      inc_drop  = 1'b0;
      case (state)
         WAIT_IDLE: if (!gmii_rx_dv_in) state_nxt = IDLE;
         IDLE: begin
            fwd = 1'b1;
            if (gmii_rx_dv_in) begin
               if (gap_cnt >= min_interframe_gap) begin
                  state_nxt = PASS;
                  inc_pass  = 1'b1;
               end else begin
                  state_nxt = DROP;
                  fwd       = 1'b0;
                  inc_drop  = 1'b1;
               end
            end
         end
         PASS: begin
            fwd = 1'b1;
            if (!gmii_rx_dv_in) state_nxt = IDLE;
         end
         DROP:    if (!gmii_rx_dv_in) state_nxt = IDLE;
         default: state_nxt = WAIT_IDLE;
      endcase
   end

   // Stage p1: registered outputs, counters and gap tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= WAIT_IDLE;
         gap_cnt        <= '1;
         rxd_p1         <= '0;
         vld_p1         <= 1'b0;
         er_p1          <= 1'b0;
         frames_passed  <= '0;
         frames_dropped <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gmii_rx_dv_in ? '0 : gap_sat_inc(gap_cnt);
         rxd_p1  <= fwd ? gmii_rxd_in   : 8'h00;
         vld_p1  <= fwd ? gmii_rx_dv_in : 1'b0;
         er_p1   <= fwd ? gmii_rx_er_in : 1'b0;
         if (stats_clear) begin
            frames_passed  <= '0;
            frames_dropped <= '0;
         end else begin
            if (inc_pass) frames_passed  <= frames_passed + CNT_ONE;
            if (inc_drop) frames_dropped <= frames_dropped + CNT_ONE;
         end
      end
   end

   assign gmii_rxd_out   = rxd_p1;
   assign gmii_rx_dv_out = vld_p1;
   assign gmii_rx_er_out = er_p1;

endmodule

// File: tb/tb_filter_gmii_ifg.sv
// Scoreboard bench for filter_gmii_ifg: the driver queues the expected registered
// output for every stimulus cycle, a monitor pops and compares one cycle later.
module tb_filter_gmii_ifg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rxd_in = 8'h00;
   logic        dv_in = 1'b0;
   logic        er_in = 1'b0;
   logic [15:0] min_gap = 16'd12;
   logic        stats_clear = 1'b0;
   logic [7:0]  rxd_out;
   logic        dv_out, er_out;
   logic [31:0] passed, dropped;
   logic [7:0]  w_rxd_out;
   logic        w_dv_out, w_er_out;
   logic [1:0]  w_passed, w_dropped;

   filter_gmii_ifg #(.C_GAP_WIDTH(16), .C_CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .gmii_rxd_in(rxd_in), .gmii_rx_dv_in(dv_in),
      .gmii_rx_er_in(er_in), .min_interframe_gap(min_gap), .stats_clear(stats_clear),
      .gmii_rxd_out(rxd_out), .gmii_rx_dv_out(dv_out), .gmii_rx_er_out(er_out),
      .frames_passed(passed), .frames_dropped(dropped));

   // Narrow-counter copy used to observe modulo wrap of the statistics counters.
   filter_gmii_ifg #(.C_GAP_WIDTH(16), .C_CNT_WIDTH(2)) dut_w (
      .clk(clk), .reset(reset), .gmii_rxd_in(rxd_in), .gmii_rx_dv_in(dv_in),
      .gmii_rx_er_in(er_in), .min_interframe_gap(min_gap), .stats_clear(stats_clear),
      .gmii_rxd_out(w_rxd_out), .gmii_rx_dv_out(w_dv_out), .gmii_rx_er_out(w_er_out),
      .frames_passed(w_passed), .frames_dropped(w_dropped));

   always #4 clk = ~clk;

   typedef struct packed {
      logic [7:0]  rxd;
      logic        dv;
      logic        er;
      logic [31:0] np;
      logic [31:0] nd;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_pass = 0;
   logic [31:0] exp_drop = 0;
   bit          blk = 1'b1;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_tests++;
         if ({rxd_out, dv_out, er_out} !== {e.rxd, e.dv, e.er}) begin
            n_fail++;
            $display("FAIL gmii_out @%0t: got rxd=%h dv=%b er=%b, expected rxd=%h dv=%b er=%b",
                     $time, rxd_out, dv_out, er_out, e.rxd, e.dv, e.er);
         end
         n_tests++;
         if ({passed, dropped} !== {e.np, e.nd}) begin
            n_fail++;
            $display("FAIL counters @%0t: got passed=%0d dropped=%0d, expected passed=%0d dropped=%0d",
                     $time, passed, dropped, e.np, e.nd);
         end
         n_tests++;
         if ({w_passed, w_dropped} !== {e.np[1:0], e.nd[1:0]}) begin
            n_fail++;
            $display("FAIL narrow_counters @%0t: got passed=%0d dropped=%0d, expected passed=%0d dropped=%0d",
                     $time, w_passed, w_dropped, e.np[1:0], e.nd[1:0]);
         end
      end
   end

   task automatic cyc(input logic [7:0] d, input logic dv, input logic er, input logic clr,
                      input logic rst, input bit fwd, input bit ip, input bit id);
      exp_t e;
      @(negedge clk);
      rxd_in = d; dv_in = dv; er_in = er; stats_clear = clr; reset = rst;
      if (rst || clr) begin
         exp_pass = 0;
         exp_drop = 0;
      end else begin
         if (ip) exp_pass = exp_pass + 1;
         if (id) exp_drop = exp_drop + 1;
      end
      e.rxd = (fwd && !rst) ? d  : 8'h00;
      e.dv  = (fwd && !rst) ? dv : 1'b0;
      e.er  = (fwd && !rst) ? er : 1'b0;
      e.np  = exp_pass;
      e.nd  = exp_drop;
      q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [7:0] d, input logic er);
      for (int i = 0; i < n; i++) begin
         cyc(d, 1'b0, er, 1'b0, 1'b0, !blk, 1'b0, 1'b0);
         blk = 1'b0;
      end
   endtask

   task automatic frame(input int len, input bit pass, input logic [7:0] seed,
                        input int er_at, input int rst_at, input bit clr0);
      bit sup;
      sup = !pass;
      for (int i = 0; i < len; i++) begin
         logic [7:0] d;
         d = seed + 8'(i * 3);
         if (i == rst_at) sup = 1'b1;
         cyc(d, 1'b1, (i == er_at), clr0 && (i == 0), (i == rst_at), !sup,
             pass && (i == 0), !pass && (i == 0));
      end
      blk = sup;
   endtask

   initial begin
      // reset state
      for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      blk = 1'b1;
      // back-to-back compliant frames at min=12
      idle(5, 8'h00, 1'b0);
      frame(64, 1, 8'h10, -1, -1, 0);
      idle(12, 8'h00, 1'b0);
      frame(64, 1, 8'h55, -1, -1, 0);
      // 11-cycle gap drops, 12 passes
      idle(11, 8'h00, 1'b0);
      frame(64, 0, 8'hA0, -1, -1, 0);
      idle(12, 8'h00, 1'b0);
      frame(64, 1, 8'h33, -1, -1, 0);
      // min=0, single idle cycles, error propagation in and out of frames
      min_gap = 16'd0;
      idle(1, 8'h0F, 1'b1);
      frame(8, 1, 8'h20, 3, -1, 0);
      idle(1, 8'h0F, 1'b1);
      frame(8, 1, 8'h40, 0, -1, 0);
      idle(1, 8'h00, 1'b0);
      frame(8, 1, 8'h60, 7, -1, 0);
      // reset mid-frame
      min_gap = 16'd12;
      idle(12, 8'h00, 1'b0);
      frame(64, 1, 8'h70, -1, 20, 0);
      idle(12, 8'h00, 1'b0);
      frame(64, 1, 8'h90, -1, -1, 0);
      // gap saturation and large minimum
      idle(1, 8'h00, 1'b0);
      min_gap = 16'hFFFF;
      idle(66000, 8'h00, 1'b0);
      frame(8, 1, 8'hB0, -1, -1, 0);
      idle(100, 8'h00, 1'b0);
      frame(8, 0, 8'hC0, -1, -1, 0);
      min_gap = 16'd20;
      idle(19, 8'h00, 1'b0);
      frame(8, 0, 8'hD0, -1, -1, 0);
      idle(20, 8'h00, 1'b0);
      frame(8, 1, 8'hE0, -1, -1, 0);
      // clear coincident with a passing frame start, then count up through wrap
      idle(25, 8'h00, 1'b0);
      frame(8, 1, 8'h01, -1, -1, 1);
      for (int k = 0; k < 4; k++) begin
         idle(25, 8'h00, 1'b0);
         frame(8, 1, 8'(8'h11 * k), -1, -1, 0);
      end
      idle(3, 8'h00, 1'b0);
      cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3, 8'h00, 1'b0);
      @(posedge clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
